// File: rtl/rggen_bus_initiator_if.sv
// Signal bundle for rggen_bus_initiator: command channel, rggen bus request/response
// and response channel. The master modport is the initiator's view.
interface rggen_bus_initiator_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int LATENCY_WIDTH = 8
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_access;
    logic [ADDRESS_WIDTH-1:0]   cmd_address;
    logic [BUS_WIDTH-1:0]       cmd_write_data;
    logic [BUS_WIDTH/8-1:0]     cmd_strobe;

    logic                       bus_valid;
    logic [1:0]                 bus_access;
    logic [ADDRESS_WIDTH-1:0]   bus_address;
    logic [BUS_WIDTH-1:0]       bus_write_data;
    logic [BUS_WIDTH/8-1:0]     bus_strobe;
    logic                       bus_ready;
    logic [1:0]                 bus_status;
    logic [BUS_WIDTH-1:0]       bus_read_data;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [1:0]                 rsp_status;
    logic [BUS_WIDTH-1:0]       rsp_read_data;
    logic [LATENCY_WIDTH-1:0]   rsp_latency;

    modport master (
        input  cmd_valid, cmd_access, cmd_address, cmd_write_data, cmd_strobe,
        output cmd_ready,
        output bus_valid, bus_access, bus_address, bus_write_data, bus_strobe,
        input  bus_ready, bus_status, bus_read_data,
        output rsp_valid, rsp_status, rsp_read_data, rsp_latency,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_access, cmd_address, cmd_write_data, cmd_strobe,
        input  cmd_ready,
        input  bus_valid, bus_access, bus_address, bus_write_data, bus_strobe,
        output bus_ready, bus_status, bus_read_data,
        input  rsp_valid, rsp_status, rsp_read_data, rsp_latency,
        output rsp_ready
    );
endinterface

// File: rtl/rggen_bus_initiator.sv
// Single-outstanding rggen bus initiator: takes one command, holds the bus request
// until ready, then returns status, read data and the measured latency.
module rggen_bus_initiator #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int LATENCY_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    rggen_bus_initiator_if.master io_bus
);
    localparam int STROBE_WIDTH = BUS_WIDTH / 8;
    localparam int LSB_WIDTH    = $clog2(STROBE_WIDTH);
    localparam logic [1:0] ACCESS_READ = 2'b10;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
        ~ADDRESS_WIDTH'((1 << LSB_WIDTH) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic                       w_cmd_fire;
    logic                       w_bus_done;
    logic                       w_cmd_is_read;
    logic [1:0]                 r_bus_access;
    logic [ADDRESS_WIDTH-1:0]   r_bus_address;
    logic [BUS_WIDTH-1:0]       r_bus_write_data;
    logic [STROBE_WIDTH-1:0]    r_bus_strobe;
    logic [LATENCY_WIDTH-1:0]   r_latency;
    logic [1:0]                 r_rsp_status;
    logic [BUS_WIDTH-1:0]       r_rsp_read_data;
    logic [LATENCY_WIDTH-1:0]   r_rsp_latency;

    assign w_cmd_fire    = (r_state == ST_IDLE) && io_bus.cmd_valid;
    assign w_bus_done    = (r_state == ST_BUSY) && io_bus.bus_ready;
    assign w_cmd_is_read = (io_bus.cmd_access == ACCESS_READ);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (io_bus.cmd_valid) w_next_state = ST_BUSY;
            ST_BUSY: if (io_bus.bus_ready) w_next_state = ST_RESP;
            ST_RESP: if (io_bus.rsp_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request fields are frozen at acceptance; the latency count saturates at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bus_access     <= '0;
            r_bus_address    <= '0;
            r_bus_write_data <= '0;
            r_bus_strobe     <= '0;
            r_latency        <= '0;
            r_rsp_status     <= '0;
            r_rsp_read_data  <= '0;
            r_rsp_latency    <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_bus_access     <= io_bus.cmd_access;
                r_bus_address    <= io_bus.cmd_address & ADDR_MASK;
                r_bus_write_data <= w_cmd_is_read ? '0 : io_bus.cmd_write_data;
                r_bus_strobe     <= w_cmd_is_read ? '1 : io_bus.cmd_strobe;
                r_latency        <= LATENCY_WIDTH'(1);
            end else if ((r_state == ST_BUSY) && !io_bus.bus_ready && (r_latency != '1)) begin
                r_latency <= r_latency + 1'b1;
            end
            if (w_bus_done) begin
                r_rsp_status    <= io_bus.bus_status;
                r_rsp_read_data <= (r_bus_access == ACCESS_READ) ? io_bus.bus_read_data : '0;
                r_rsp_latency   <= r_latency;
            end
        end
    end

    assign io_bus.cmd_ready      = (r_state == ST_IDLE);
    assign io_bus.bus_valid      = (r_state == ST_BUSY);
    assign io_bus.bus_access     = r_bus_access;
    assign io_bus.bus_address    = r_bus_address;
    assign io_bus.bus_write_data = r_bus_write_data;
    assign io_bus.bus_strobe     = r_bus_strobe;
    assign io_bus.rsp_valid      = (r_state == ST_RESP);
    assign io_bus.rsp_status     = r_rsp_status;
    assign io_bus.rsp_read_data  = r_rsp_read_data;
    assign io_bus.rsp_latency    = r_rsp_latency;
endmodule

// File: tb/tb_rggen_bus_initiator.sv
// Directed scoreboard bench for rggen_bus_initiator: a 32-bit/8-bit-latency instance
// for the main sequence and a 4-bit-latency instance for saturation.
module tb_rggen_bus_initiator;
    typedef struct packed {
        logic [1:0]  status;
        logic [31:0] readData;
        logic [7:0]  latency;
    } rsp_t;

    logic clock = 1'b0;
    logic rstN;
    int   vectorCount = 0;
    int   missCount   = 0;
    rsp_t expQ[$];

    always #5 clock = ~clock;

    rggen_bus_initiator_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .LATENCY_WIDTH(8)) if0 ();
    rggen_bus_initiator_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .LATENCY_WIDTH(4)) if1 ();

    rggen_bus_initiator #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .LATENCY_WIDTH(8)) dut0 (
        .i_clk   (clock),
        .i_rst_n (rstN),
        .io_bus  (if0.master)
    );

    rggen_bus_initiator #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .LATENCY_WIDTH(4)) dut1 (
        .i_clk   (clock),
        .i_rst_n (rstN),
        .io_bus  (if1.master)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives a command onto if0 and records the response the model predicts for it.
    task automatic applyStimulus(input logic [1:0] access, input logic [7:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input logic [1:0] status, input logic [31:0] rdata, input int lat);
        rsp_t exp;
        exp.status   = status;
        exp.readData = (access == 2'b10) ? rdata : 32'h0;
        exp.latency  = (lat > 255) ? 8'hFF : 8'(lat);
        expQ.push_back(exp);
        if0.cmd_valid      = 1'b1;
        if0.cmd_access     = access;
        if0.cmd_address    = addr;
        if0.cmd_write_data = wdata;
        if0.cmd_strobe     = strb;
    endtask

    task automatic checkResponse(input string tag);
        rsp_t exp;
        checkOutput({tag, "_sbDepth"}, 64'(expQ.size()), 64'd1);
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkOutput({tag, "_status"}, 64'(if0.rsp_status), 64'(exp.status));
            checkOutput({tag, "_readData"}, 64'(if0.rsp_read_data), 64'(exp.readData));
            checkOutput({tag, "_latency"}, 64'(if0.rsp_latency), 64'(exp.latency));
        end
    endtask

    // One full transaction on if0: responder readies on the lat-th valid cycle, then the
    // response is held for holdCycles with a competing command waiting.
    task automatic doTxn(input string tag, input logic [1:0] access, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input int lat,
                         input logic [1:0] status, input logic [31:0] rdata, input int holdCycles);
        logic [45:0] expBus;
        expBus = {access, addr & 8'hFC, (access == 2'b10) ? 4'hF : strb,
                  (access == 2'b10) ? 32'h0 : wdata};
        checkOutput({tag, "_cmdReady"}, 64'(if0.cmd_ready), 64'd1);
        applyStimulus(access, addr, wdata, strb, status, rdata, lat);
        @(negedge clock);
        if0.cmd_valid = 1'b0;
        checkOutput({tag, "_cmdBusy"}, 64'(if0.cmd_ready), 64'd0);
        for (int i = 1; i <= lat; i++) begin
            checkOutput({tag, "_busValid"}, 64'(if0.bus_valid), 64'd1);
            checkOutput({tag, "_busFields"},
                        64'({if0.bus_access, if0.bus_address, if0.bus_strobe, if0.bus_write_data}),
                        64'(expBus));
            if (i == lat) begin
                if0.bus_ready     = 1'b1;
                if0.bus_status    = status;
                if0.bus_read_data = rdata;
            end
            @(negedge clock);
            if0.bus_ready     = 1'b0;
            if0.bus_status    = 2'b11;
            if0.bus_read_data = 32'h5A5A5A5A;
        end
        checkOutput({tag, "_busDone"}, 64'(if0.bus_valid), 64'd0);
        checkOutput({tag, "_rspValid"}, 64'(if0.rsp_valid), 64'd1);
        for (int i = 0; i < holdCycles; i++) begin
            if0.cmd_valid   = 1'b1;
            if0.cmd_access  = 2'b11;
            if0.cmd_address = 8'h7F;
            checkOutput({tag, "_holdCmdReady"}, 64'(if0.cmd_ready), 64'd0);
            checkOutput({tag, "_holdBusValid"}, 64'(if0.bus_valid), 64'd0);
            checkOutput({tag, "_holdRspValid"}, 64'(if0.rsp_valid), 64'd1);
            if (expQ.size() > 0) begin
                checkOutput({tag, "_holdRsp"},
                            64'({if0.rsp_status, if0.rsp_read_data, if0.rsp_latency}),
                            64'({expQ[0].status, expQ[0].readData, expQ[0].latency}));
            end
            @(negedge clock);
        end
        checkResponse(tag);
        if0.rsp_ready = 1'b1;
        @(negedge clock);
        if0.rsp_ready = 1'b0;
        if0.cmd_valid = 1'b0;
        checkOutput({tag, "_rspDone"}, 64'(if0.rsp_valid), 64'd0);
    endtask

    initial begin
        rstN = 1'b0;
        if0.cmd_valid = 1'b0; if0.cmd_access = 2'b00; if0.cmd_address = 8'h0;
        if0.cmd_write_data = 32'h0; if0.cmd_strobe = 4'h0;
        if0.bus_ready = 1'b0; if0.bus_status = 2'b00; if0.bus_read_data = 32'h0;
        if0.rsp_ready = 1'b0;
        if1.cmd_valid = 1'b0; if1.cmd_access = 2'b00; if1.cmd_address = 8'h0;
        if1.cmd_write_data = 32'h0; if1.cmd_strobe = 4'h0;
        if1.bus_ready = 1'b0; if1.bus_status = 2'b00; if1.bus_read_data = 32'h0;
        if1.rsp_ready = 1'b0;
        repeat (2) @(negedge clock);

        checkOutput("rstCmdReady", 64'(if0.cmd_ready), 64'd1);
        checkOutput("rstBus", 64'({if0.bus_valid, if0.bus_access, if0.bus_address,
                                   if0.bus_strobe, if0.bus_write_data}), 64'd0);
        checkOutput("rstRsp", 64'({if0.rsp_valid, if0.rsp_status, if0.rsp_read_data,
                                   if0.rsp_latency}), 64'd0);
        checkOutput("rstW4Latency", 64'(if1.rsp_latency), 64'd0);
        rstN = 1'b1;
        @(negedge clock);

        doTxn("rd24",  2'b10, 8'h24, 32'h11111111, 4'h0,    3, 2'b00, 32'hDEADBEEF, 0);
        doTxn("wr13",  2'b11, 8'h13, 32'h12345678, 4'b0101, 1, 2'b00, 32'h0,        0);
        doTxn("pw",    2'b01, 8'h0A, 32'hA5A5A5A5, 4'hF,    2, 2'b10, 32'hFFFFFFFF, 0);
        doTxn("hold",  2'b10, 8'h30, 32'h0,        4'h0,    2, 2'b00, 32'h600DF00D, 5);
        doTxn("b2b",   2'b11, 8'h04, 32'h0BADCAFE, 4'b1000, 1, 2'b11, 32'h0,        0);
        doTxn("acc00", 2'b00, 8'hFF, 32'h00000001, 4'b0001, 4, 2'b11, 32'h77777777, 0);

        // Saturation on the narrow counter, with the request held through a long stall.
        if1.cmd_valid      = 1'b1;
        if1.cmd_access     = 2'b11;
        if1.cmd_address    = 8'h2A;
        if1.cmd_write_data = 32'hCAFEF00D;
        if1.cmd_strobe     = 4'b1100;
        @(negedge clock);
        if1.cmd_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            checkOutput("w4BusHold",
                        64'({if1.bus_valid, if1.bus_access, if1.bus_address, if1.bus_strobe,
                             if1.bus_write_data}),
                        64'({1'b1, 2'b11, 8'h28, 4'b1100, 32'hCAFEF00D}));
            if (i == 20) begin
                if1.bus_ready  = 1'b1;
                if1.bus_status = 2'b00;
            end
            @(negedge clock);
        end
        if1.bus_ready = 1'b0;
        checkOutput("w4RspValid", 64'(if1.rsp_valid), 64'd1);
        checkOutput("w4Latency", 64'(if1.rsp_latency), 64'd15);
        checkOutput("w4ReadData", 64'(if1.rsp_read_data), 64'd0);
        if1.rsp_ready = 1'b1;
        @(negedge clock);
        if1.rsp_ready = 1'b0;
        checkOutput("w4Idle", 64'(if1.cmd_ready), 64'd1);

        // Reset in the middle of BUSY discards the request and its pending response.
        applyStimulus(2'b10, 8'h40, 32'h0, 4'h0, 2'b00, 32'h0, 1);
        @(negedge clock);
        if0.cmd_valid = 1'b0;
        checkOutput("rstMidBusy", 64'(if0.bus_valid), 64'd1);
        @(negedge clock);
        #2 rstN = 1'b0;
        #1;
        checkOutput("rstMidBusValid", 64'(if0.bus_valid), 64'd0);
        checkOutput("rstMidRspValid", 64'(if0.rsp_valid), 64'd0);
        checkOutput("rstMidCmdReady", 64'(if0.cmd_ready), 64'd1);
        checkOutput("rstMidBus", 64'({if0.bus_access, if0.bus_address, if0.bus_strobe,
                                      if0.bus_write_data}), 64'd0);
        void'(expQ.pop_back());
        @(negedge clock);
        rstN = 1'b1;
        @(negedge clock);
        checkOutput("postRstRspValid", 64'(if0.rsp_valid), 64'd0);
        doTxn("postRst", 2'b10, 8'h44, 32'h0, 4'h0, 2, 2'b00, 32'h13579BDF, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
